// File: rtl/hsv_blob_pkg.sv
// Shared constants, result record and FSM encoding for the HSV blob tracker.
package hsv_blob_pkg;

    localparam int unsigned CW        = 13;
    localparam int unsigned SUM_W     = 28;
    localparam int unsigned CNT_W     = 19;
    localparam int unsigned COLS      = 640;
    localparam int unsigned ROWS      = 480;
    localparam int unsigned MIN_COUNT = 64;
    localparam int unsigned CX_W      = 10;
    localparam int unsigned CY_W      = 9;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        PUBLISH
    } tracker_state_t;

    typedef struct packed {
        logic             found;
        logic [CX_W-1:0]  cx;
        logic [CY_W-1:0]  cy;
        logic [CW-1:0]    x_min;
        logic [CW-1:0]    x_max;
        logic [CW-1:0]    y_min;
        logic [CW-1:0]    y_max;
        logic [CNT_W-1:0] count;
    } blob_result_t;

endpackage

// File: rtl/hsv_blob_tracker_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DIVIDEND_W cycles per divide.
// done is high during the cycle that computes the final bit; quotient is complete the cycle after.
module seq_divider
    import hsv_blob_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = SUM_W,
    parameter int unsigned DIVISOR_W  = CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int unsigned STEP_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  run_q, run_d;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        step_d = step_q;
        run_d  = run_q;
        trial  = {rem_q, quot_q[DIVIDEND_W-1]};
        diff   = trial - {1'b0, dvsr_q};
        done   = run_q && (step_q == STEP_W'(DIVIDEND_W - 1));

        if (start) begin
            quot_d = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
            step_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            // Dividend bits shift out of the top while quotient bits shift in below.
            if (trial >= {1'b0, dvsr_q}) begin
                rem_d  = diff[DIVISOR_W-1:0];
                quot_d = {quot_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d  = trial[DIVISOR_W-1:0];
                quot_d = {quot_q[DIVIDEND_W-2:0], 1'b0};
            end
            step_d = step_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            step_q <= step_d;
            run_q  <= run_d;
        end
    end

    assign quotient = quot_q;

endmodule

// File: rtl/hsv_blob_tracker.sv
// Per-frame colour-window blob tracker: count, bbox and centroid of matching HSV pixels.
// Optional bbox/crosshair overlay output under `HSV_BLOB_OVERLAY_EN.
module hsv_blob_tracker #(
    parameter int unsigned COLS      = hsv_blob_pkg::COLS,
    parameter int unsigned ROWS      = hsv_blob_pkg::ROWS,
    parameter int unsigned CW        = hsv_blob_pkg::CW,
    parameter int unsigned SUM_W     = hsv_blob_pkg::SUM_W,
    parameter int unsigned CNT_W     = hsv_blob_pkg::CNT_W,
    parameter int unsigned MIN_COUNT = hsv_blob_pkg::MIN_COUNT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic [CW-1:0]      row,
    input  logic [CW-1:0]      col,
    input  logic signed [13:0] H_in,
    input  logic [7:0]         S_in,
    input  logic [7:0]         V_in,
    input  logic               VGA_VS,
    input  logic signed [13:0] h_lo,
    input  logic signed [13:0] h_hi,
    input  logic [7:0]         s_min,
    input  logic [7:0]         v_min,
    output logic               obj_found,
    output logic [9:0]         cx,
    output logic [8:0]         cy,
    output logic [CW-1:0]      x_min,
    output logic [CW-1:0]      x_max,
    output logic [CW-1:0]      y_min,
    output logic [CW-1:0]      y_max,
    output logic [CNT_W-1:0]   pix_count,
    output logic               result_valid,
    output logic               busy
`ifdef HSV_BLOB_OVERLAY_EN
    ,
    output logic               overlay
`endif
);

    import hsv_blob_pkg::tracker_state_t;
    import hsv_blob_pkg::blob_result_t;
    import hsv_blob_pkg::IDLE;
    import hsv_blob_pkg::DIV;
    import hsv_blob_pkg::PUBLISH;
    import hsv_blob_pkg::CX_W;
    import hsv_blob_pkg::CY_W;

    localparam logic [CW-1:0] XMIN_INIT = CW'(COLS - 1);
    localparam logic [CW-1:0] YMIN_INIT = CW'(ROWS - 1);

    tracker_state_t   state_q, state_d;
    logic             vs_q;
    logic             frame_edge;
    logic             pix_match;
    logic             publish;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [SUM_W:0]   sx_sum, sy_sum;
    logic [CW-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
    logic [CW-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;

    logic [CNT_W-1:0] snap_cnt_q;
    logic [CW-1:0]    snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q;

    blob_result_t     res_q, res_d;
    logic             result_valid_q;

    logic [SUM_W-1:0] quot_x, quot_y;
    logic             done_x, done_y;

    assign frame_edge = vs_q && !VGA_VS;

    assign pix_match = pix_valid
                    && (row < CW'(ROWS)) && (col < CW'(COLS))
                    && (H_in >= h_lo) && (H_in <= h_hi)
                    && (S_in >= s_min) && (V_in >= v_min);

    // Edge clears first, so a pixel matching in the edge cycle seeds the new frame.
    always_comb begin
        cnt_d  = frame_edge ? '0        : cnt_q;
        sx_d   = frame_edge ? '0        : sx_q;
        sy_d   = frame_edge ? '0        : sy_q;
        xmin_d = frame_edge ? XMIN_INIT : xmin_q;
        xmax_d = frame_edge ? '0        : xmax_q;
        ymin_d = frame_edge ? YMIN_INIT : ymin_q;
        ymax_d = frame_edge ? '0        : ymax_q;
        sx_sum = {1'b0, sx_d} + (SUM_W + 1)'(col);
        sy_sum = {1'b0, sy_d} + (SUM_W + 1)'(row);

        if (pix_match) begin
            if (cnt_d != '1) begin
                cnt_d = cnt_d + 1'b1;
            end
            sx_d = sx_sum[SUM_W] ? '1 : sx_sum[SUM_W-1:0];
            sy_d = sy_sum[SUM_W] ? '1 : sy_sum[SUM_W-1:0];
            if (col < xmin_d) xmin_d = col;
            if (col > xmax_d) xmax_d = col;
            if (row < ymin_d) ymin_d = row;
            if (row > ymax_d) ymax_d = row;
        end
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_edge) state_d = DIV;
            end
            DIV: begin
                if (!frame_edge && done_x && done_y) state_d = PUBLISH;
            end
            PUBLISH: begin
                if (frame_edge) begin
                    state_d = DIV;
                end else begin
                    publish = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Quotients only matter for found blobs; divide-by-zero garbage is masked here.
    always_comb begin
        res_d = res_q;
        if (publish) begin
            res_d       = '0;
            res_d.count = snap_cnt_q;
            if (snap_cnt_q >= CNT_W'(MIN_COUNT)) begin
                res_d.found = 1'b1;
                res_d.cx    = (|quot_x[SUM_W-1:CX_W]) ? '1 : quot_x[CX_W-1:0];
                res_d.cy    = (|quot_y[SUM_W-1:CY_W]) ? '1 : quot_y[CY_W-1:0];
                res_d.x_min = snap_xmin_q;
                res_d.x_max = snap_xmax_q;
                res_d.y_min = snap_ymin_q;
                res_d.y_max = snap_ymax_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            vs_q           <= 1'b0;
            cnt_q          <= '0;
            sx_q           <= '0;
            sy_q           <= '0;
            xmin_q         <= XMIN_INIT;
            xmax_q         <= '0;
            ymin_q         <= YMIN_INIT;
            ymax_q         <= '0;
            snap_cnt_q     <= '0;
            snap_xmin_q    <= '0;
            snap_xmax_q    <= '0;
            snap_ymin_q    <= '0;
            snap_ymax_q    <= '0;
            res_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_q           <= VGA_VS;
            cnt_q          <= cnt_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            xmin_q         <= xmin_d;
            xmax_q         <= xmax_d;
            ymin_q         <= ymin_d;
            ymax_q         <= ymax_d;
            res_q          <= res_d;
            result_valid_q <= publish;
            if (frame_edge) begin
                snap_cnt_q  <= cnt_q;
                snap_xmin_q <= xmin_q;
                snap_xmax_q <= xmax_q;
                snap_ymin_q <= ymin_q;
                snap_ymax_q <= ymax_q;
            end
        end
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div_x (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (frame_edge),
        .dividend (sx_q),
        .divisor  (cnt_q),
        .quotient (quot_x),
        .done     (done_x)
    );

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div_y (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (frame_edge),
        .dividend (sy_q),
        .divisor  (cnt_q),
        .quotient (quot_y),
        .done     (done_y)
    );

    assign obj_found    = res_q.found;
    assign cx           = res_q.cx;
    assign cy           = res_q.cy;
    assign x_min        = res_q.x_min;
    assign x_max        = res_q.x_max;
    assign y_min        = res_q.y_min;
    assign y_max        = res_q.y_max;
    assign pix_count    = res_q.count;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == DIV);

`ifdef HSV_BLOB_OVERLAY_EN
    logic overlay_q, overlay_d;
    logic in_x, in_y, on_hedge, on_vedge, on_cross;

    always_comb begin
        in_x      = (col >= res_q.x_min) && (col <= res_q.x_max);
        in_y      = (row >= res_q.y_min) && (row <= res_q.y_max);
        on_hedge  = ((row == res_q.y_min) || (row == res_q.y_max)) && in_x;
        on_vedge  = ((col == res_q.x_min) || (col == res_q.x_max)) && in_y;
        on_cross  = ((row == CW'(res_q.cy)) || (col == CW'(res_q.cx))) && in_x && in_y;
        overlay_d = pix_valid && res_q.found && (on_hedge || on_vedge || on_cross);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overlay_q <= 1'b0;
        end else begin
            overlay_q <= overlay_d;
        end
    end

    assign overlay = overlay_q;
`endif

endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Self-checking bench for hsv_blob_tracker: directed frames plus randomized traffic
// checked against a per-frame reference model of the tracker's published results.
module tb_hsv_blob_tracker;

    localparam int LAT  = 30;
    localparam int MINC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               pix_valid;
    logic [12:0]        row, col;
    logic signed [13:0] H_in, h_lo, h_hi;
    logic [7:0]         S_in, V_in, s_min, v_min;
    logic               VGA_VS;
    logic               obj_found;
    logic [9:0]         cx;
    logic [8:0]         cy;
    logic [12:0]        x_min, x_max, y_min, y_max;
    logic [18:0]        pix_count;
    logic               result_valid;
    logic               busy;

    hsv_blob_tracker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_valid    (pix_valid),
        .row          (row),
        .col          (col),
        .H_in         (H_in),
        .S_in         (S_in),
        .V_in         (V_in),
        .VGA_VS       (VGA_VS),
        .h_lo         (h_lo),
        .h_hi         (h_hi),
        .s_min        (s_min),
        .v_min        (v_min),
        .obj_found    (obj_found),
        .cx           (cx),
        .cy           (cy),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_min        (y_min),
        .y_max        (y_max),
        .pix_count    (pix_count),
        .result_valid (result_valid),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_seen  = 0;
    int rv0;

    // Reference model: running frame statistics, pending result, published result.
    int     f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;
    longint f_sx, f_sy;
    bit     prev_vs;
    bit     p_valid;
    int     p_e, p_due;
    int     p_found, p_cx, p_cy, p_xmin, p_xmax, p_ymin, p_ymax, p_cnt;
    int     e_found, e_cx, e_cy, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic frame_clear();
        f_cnt  = 0;
        f_sx   = 0;
        f_sy   = 0;
        f_xmin = 639;
        f_xmax = 0;
        f_ymin = 479;
        f_ymax = 0;
    endtask

    task automatic model_reset();
        frame_clear();
        prev_vs = 1'b0;
        p_valid = 1'b0;
        e_found = 0; e_cx = 0; e_cy = 0; e_cnt = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    endtask

    task automatic monitor();
        bit rv_exp;
        rv_exp = p_valid && (cyc == p_due);
        if (result_valid === 1'b1) rv_seen++;
        check("result_valid", result_valid, rv_exp);
        if (rv_exp) begin
            e_found = p_found; e_cx = p_cx; e_cy = p_cy; e_cnt = p_cnt;
            e_xmin = p_xmin; e_xmax = p_xmax; e_ymin = p_ymin; e_ymax = p_ymax;
            p_valid = 1'b0;
        end
        if (p_valid && cyc > p_e && cyc <= p_e + LAT - 2) check("busy_div", busy, 1);
        else if (!p_valid) check("busy_idle", busy, 0);
        if (rv_exp || (cyc % 8) == 0) begin
            check("obj_found", obj_found, e_found);
            check("cx", cx, e_cx);
            check("cy", cy, e_cy);
            check("x_min", x_min, e_xmin);
            check("x_max", x_max, e_xmax);
            check("y_min", y_min, e_ymin);
            check("y_max", y_max, e_ymax);
            check("pix_count", pix_count, e_cnt);
        end
    endtask

    task automatic model(input bit rst_n, input bit pv, input int r, input int c,
                         input int h, input int s, input int v, input bit vs);
        bit frame_e, hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        frame_e = prev_vs && !vs;
        if (frame_e) begin
            p_valid = 1'b1;
            p_e     = cyc;
            p_due   = cyc + LAT;
            p_cnt   = f_cnt;
            if (f_cnt >= MINC) begin
                p_found = 1;
                p_cx    = int'(f_sx / f_cnt);
                p_cy    = int'(f_sy / f_cnt);
                p_xmin  = f_xmin; p_xmax = f_xmax;
                p_ymin  = f_ymin; p_ymax = f_ymax;
            end else begin
                p_found = 0; p_cx = 0; p_cy = 0;
                p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0;
            end
            frame_clear();
        end
        hit = pv && (r < 480) && (c < 640) && (h >= int'(h_lo)) && (h <= int'(h_hi))
              && (s >= int'(s_min)) && (v >= int'(v_min));
        if (hit) begin
            if (f_cnt < (1 << 19) - 1) f_cnt++;
            f_sx += c;
            f_sy += r;
            if (c < f_xmin) f_xmin = c;
            if (c > f_xmax) f_xmax = c;
            if (r < f_ymin) f_ymin = r;
            if (r > f_ymax) f_ymax = r;
        end
        prev_vs = vs;
    endtask

    task automatic step(input bit rst_n, input bit pv, input int r, input int c,
                        input int h, input int s, input int v, input bit vs);
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        reset_n   = rst_n;
        pix_valid = pv;
        row       = 13'(r);
        col       = 13'(c);
        H_in      = 14'(h);
        S_in      = 8'(s);
        V_in      = 8'(v);
        VGA_VS    = vs;
        model(rst_n, pv, r, c, h, s, v, vs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    endtask

    task automatic pix(input int r, input int c, input int h, input int s, input int v);
        step(1'b1, 1'b1, r, c, h, s, v, 1'b1);
    endtask

    task automatic vs_edge();
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; row = '0; col = '0;
        H_in = '0; S_in = '0; V_in = '0; VGA_VS = 1'b1;
        h_lo = 14'sd40; h_hi = 14'sd60; s_min = 8'd100; v_min = 8'd100;
        model_reset();

        // Reset held with random stimulus
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'($urandom), int'($urandom_range(0, 700)), int'($urandom_range(0, 700)),
                 int'($urandom_range(0, 100)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom));
        idle(3);
        check("rst_found", obj_found, 0);
        check("rst_count", pix_count, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", rv_seen, 0);

        // Solid 20x20 square with rejected hue/saturation pixels
        for (int r = 200; r < 220; r++)
            for (int c = 100; c < 120; c++) pix(r, c, 50, 200, 200);
        for (int i = 0; i < 20; i++) pix(300, 300 + i, 70, 200, 200);
        for (int i = 0; i < 10; i++) pix(300, 400 + i, 50, 99, 200);
        vs_edge();
        idle(LAT);
        check("sq_found", obj_found, 1);
        check("sq_count", pix_count, 400);
        check("sq_cx", cx, 109);
        check("sq_cy", cy, 209);
        check("sq_xmin", x_min, 100);
        check("sq_xmax", x_max, 119);
        check("sq_ymin", y_min, 200);
        check("sq_ymax", y_max, 219);

        // Below threshold
        for (int i = 0; i < 10; i++) pix(50, 50 + i, 45, 150, 150);
        vs_edge();
        idle(LAT);
        check("low_count", pix_count, 10);
        check("low_found", obj_found, 0);
        check("low_cx", cx, 0);
        check("low_xmax", x_max, 0);

        // Signed hue window
        h_lo = -14'sd30; h_hi = -14'sd10;
        for (int i = 0; i < 70; i++) pix(10, i, -20, 200, 200);
        for (int i = 0; i < 10; i++) pix(11, i, 20, 200, 200);
        for (int i = 0; i < 10; i++) pix(12, i, -31, 200, 200);
        vs_edge();
        idle(LAT);
        check("hue_count", pix_count, 70);
        check("hue_cx", cx, 34);
        check("hue_cy", cy, 10);

        // Abort: second edge 10 cycles after the first
        h_lo = 14'sd40; h_hi = 14'sd60;
        for (int i = 0; i < 100; i++) pix(50, i, 50, 200, 200);
        rv0 = rv_seen;
        vs_edge();
        for (int i = 0; i < 9; i++) pix(60, 10 + i, 50, 200, 200);
        vs_edge();
        idle(LAT + 5);
        check("abort_pulses", rv_seen - rv0, 1);
        check("abort_count", pix_count, 9);
        check("abort_found", obj_found, 0);

        // Active-area boundaries and a pixel coincident with the edge
        for (int i = 0; i < 64; i++) pix(479, 576 + i, 50, 200, 200);
        pix(479, 640, 50, 200, 200);
        pix(480, 600, 50, 200, 200);
        step(1'b1, 1'b0, 479, 600, 50, 200, 200, 1'b1);
        step(1'b1, 1'b1, 5, 5, 50, 200, 200, 1'b0);
        idle(LAT);
        check("bnd_count", pix_count, 64);
        check("bnd_xmin", x_min, 576);
        check("bnd_xmax", x_max, 639);
        check("bnd_ymax", y_max, 479);
        check("bnd_cx", cx, 607);
        check("bnd_cy", cy, 479);
        vs_edge();
        idle(LAT);
        check("edge_pix_count", pix_count, 1);

        // Reset in the middle of a divide
        for (int i = 0; i < 80; i++) pix(100, 200 + i, 50, 200, 200);
        rv0 = rv_seen;
        vs_edge();
        idle(10);
        step(1'b0, 1'b1, 100, 100, 50, 200, 200, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        idle(LAT + 10);
        check("mr_pulses", rv_seen - rv0, 0);
        check("mr_count", pix_count, 0);
        check("mr_found", obj_found, 0);

        // Randomized traffic with occasional edges (including aborts) and one reset
        for (int i = 0; i < 3000; i++) begin
            int r, c, h, s, v;
            bit pv, vs, rst;
            r   = ($urandom % 4 == 0) ? int'($urandom_range(0, 500)) : int'($urandom_range(460, 485));
            c   = ($urandom % 4 == 0) ? int'($urandom_range(0, 660)) : int'($urandom_range(600, 645));
            h   = ($urandom % 10 < 7) ? int'($urandom_range(35, 65)) : int'($urandom_range(0, 180)) - 60;
            s   = int'($urandom_range(80, 255));
            v   = int'($urandom_range(80, 255));
            pv  = ($urandom % 8) != 0;
            vs  = ($urandom_range(0, 149) != 0);
            rst = (i != 1500);
            step(rst, pv, r, c, h, s, v, vs);
        end
        idle(LAT + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
